pc_fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter, drives the word address of the asynchronous instruction ROM (`instr_mem`), and captures the returned word into the IF/ID pipeline register. Sits directly upstream of `instr_mem` and feeds the decode stage. Handles sequential fetch, branch/JAL/JALR redirection, stall, flush, and an optional halt-on-zero-word detector.

---
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction ROM and fills IF/ID.
// Optional halt-on-zero-word detector enabled by defining HALT_ON_ZERO_EN.
module pc_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [1:0]               pc_src,
  input  logic [PC_WIDTH-1:0]      imm_ext,
  input  logic [PC_WIDTH-1:0]      alu_result,
  output logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    RD,
  output logic [PC_WIDTH-1:0]      pc_d,
  output logic [PC_WIDTH-1:0]      pc_plus4_d,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic                     valid_d,
  output logic                     halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [DATA_WIDTH-1:0] BUBBLE = DATA_WIDTH'(32'h0000_0013);
  localparam logic [PC_WIDTH-1:0]   FOUR   = PC_WIDTH'(4);

  state_t                  state, state_next;
  logic [PC_WIDTH-1:0]     pc, pc_next;
  logic [PC_WIDTH-1:0]     pc_d_next, pc_plus4_next;
  logic [DATA_WIDTH-1:0]   instr_next;
  logic                    valid_next;
  logic                    redirect;
  logic [PC_WIDTH-1:0]     target;
  logic                    zero_word;

  assign A        = pc[ADDRESS_WIDTH+1:2];
  assign redirect = (pc_src == 2'b01) || (pc_src == 2'b10);
  // JALR clears only bit 0; a misaligned bit 1 is left for downstream to trap.
  assign target   = (pc_src == 2'b01) ? (pc_d + imm_ext) : (alu_result & ~PC_WIDTH'(1));

`ifdef HALT_ON_ZERO_EN
  assign zero_word = (RD == '0);
  assign halted    = (state == HALT);
`else
  assign zero_word = 1'b0;
  assign halted    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pc_d       <= RESET_PC;
      pc_plus4_d <= RESET_PC + FOUR;
      instr_d    <= BUBBLE;
      valid_d    <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pc_d       <= pc_d_next;
      pc_plus4_d <= pc_plus4_next;
      instr_d    <= instr_next;
      valid_d    <= valid_next;
    end
  end

  // A bubble only replaces the instruction and valid bit; pc_d/pc_plus4_d keep their values.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    pc_d_next     = pc_d;
    pc_plus4_next = pc_plus4_d;
    instr_next    = instr_d;
    valid_next    = valid_d;
    case (state)
      BOOT: begin
        instr_next = BUBBLE;
        valid_next = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_next    = target;
          instr_next = BUBBLE;
          valid_next = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_next = BUBBLE;
            valid_next = 1'b0;
          end
        end else if (pc_src == 2'b11) begin
          instr_next = BUBBLE;
          valid_next = 1'b0;
        end else if (zero_word) begin
          instr_next = BUBBLE;
          valid_next = 1'b0;
          state_next = HALT;
        end else begin
          pc_next = pc + FOUR;
          if (flush) begin
            instr_next = BUBBLE;
            valid_next = 1'b0;
          end else begin
            instr_next    = RD;
            valid_next    = 1'b1;
            pc_d_next     = pc;
            pc_plus4_next = pc + FOUR;
          end
        end
      end
      HALT: begin
        instr_next = BUBBLE;
        valid_next = 1'b0;
        if (redirect) begin
          pc_next    = target;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes expected IF/ID entries, a monitor pops them.
// Honours HALT_ON_ZERO_EN to match the build of the design.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rst_w_n;
  logic        stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext, alu_result;
  logic [7:0]  A, A_w;
  logic [31:0] RD, RD_w;
  logic [31:0] pc_d, pc_plus4_d, instr_d;
  logic [31:0] pc_d_w, pc_plus4_d_w, instr_d_w;
  logic        valid_d, halted, valid_d_w, halted_w;
  logic        last_stall = 1'b0;
  logic [31:0] rom [256];
  exp_t        sb [$];
  exp_t        mon_e;
  int          n_vectors = 0;
  int          n_miscompares = 0;

  always #5 clk = ~clk;

  assign RD   = rom[A];
  assign RD_w = rom[A_w];

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_src(pc_src),
    .imm_ext(imm_ext), .alu_result(alu_result), .A(A), .RD(RD), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .instr_d(instr_d), .valid_d(valid_d), .halted(halted)
  );

  pc_fetch_unit #(.RESET_PC(32'h0000_03FC)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .stall(1'b0), .flush(1'b0), .pc_src(2'b00),
    .imm_ext(32'h0), .alu_result(32'h0), .A(A_w), .RD(RD_w), .pc_d(pc_d_w),
    .pc_plus4_d(pc_plus4_d_w), .instr_d(instr_d_w), .valid_d(valid_d_w), .halted(halted_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = rom[pc[9:2]];
    sb.push_back(e);
  endtask

  always @(posedge clk) last_stall <= stall;

  // A fresh valid entry appears only after an unstalled edge; held entries are not re-checked.
  always @(negedge clk) begin
    if (valid_d && !last_stall) begin
      if (sb.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL sb_unexpected: got pc_d %h instr %h, want no output", pc_d, instr_d);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc_d", pc_d, mon_e.pc);
        check("sb_pc_plus4_d", pc_plus4_d, mon_e.pc4);
        check("sb_instr_d", instr_d, mon_e.instr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] a_exp,
                             input logic v_exp, input logic h_exp);
    check({tag, "_A"}, {24'h0, A}, a_exp);
    check({tag, "_valid"}, {31'h0, valid_d}, {31'h0, v_exp});
    check({tag, "_halted"}, {31'h0, halted}, {31'h0, h_exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[4]     = 32'h0000_0000;
    rst_n      = 1'b0;
    rst_w_n    = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    pc_src     = 2'b00;
    imm_ext    = 32'h0;
    alu_result = 32'h0;
    #12;
    check("rst_instr", instr_d, 32'h13);
    check("rst_pc_d", pc_d, 32'h0);
    check("rst_pc_plus4", pc_plus4_d, 32'h4);
    checkOutput("rst", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    step();
    checkOutput("boot", 32'h0, 1'b0, 1'b0);
    applyStimulus(32'h0); step();
    applyStimulus(32'h4); step();
    applyStimulus(32'h8); step();

    pc_src = 2'b01; imm_ext = 32'h10; step();
    checkOutput("branch", 32'd6, 1'b0, 1'b0);
    pc_src = 2'b00; applyStimulus(32'h18); step();

    pc_src = 2'b10; alu_result = 32'h21; stall = 1'b1; step();
    checkOutput("jalr_stall", 32'd8, 1'b0, 1'b0);
    pc_src = 2'b00; stall = 1'b0; applyStimulus(32'h20); step();
    check("jalr_word8", instr_d, rom[8]);

    pc_src = 2'b01; imm_ext = 32'hFFFF_FFE4; step();
    pc_src = 2'b00; applyStimulus(32'h4); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr_d, rom[1]);
      check("stall_pc_d", pc_d, 32'h4);
      checkOutput("stall", 32'd2, 1'b1, 1'b0);
    end
    flush = 1'b1; step();
    check("flush_instr", instr_d, 32'h13);
    check("flush_pc_d", pc_d, 32'h4);
    checkOutput("flush", 32'd2, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    applyStimulus(32'h8); step();
    applyStimulus(32'hC); step();

`ifdef HALT_ON_ZERO_EN
    step();
    checkOutput("halt", 32'd4, 1'b0, 1'b1);
    step();
    checkOutput("halt_hold", 32'd4, 1'b0, 1'b1);
`else
    applyStimulus(32'h10); step();
    check("zero_word_instr", instr_d, 32'h0);
    checkOutput("zero_word", 32'd5, 1'b1, 1'b0);
    applyStimulus(32'h14); step();
`endif

    pc_src = 2'b10; alu_result = 32'h0; step();
    checkOutput("redir_zero", 32'd0, 1'b0, 1'b0);
    pc_src = 2'b00; applyStimulus(32'h0); step();
    pc_src = 2'b11; step();
    checkOutput("hold", 32'd1, 1'b0, 1'b0);
    pc_src = 2'b00; applyStimulus(32'h4); step();

    pc_src = 2'b10; alu_result = 32'hFFFF_FFFD; step();
    checkOutput("top_pc", 32'd255, 1'b0, 1'b0);
    pc_src = 2'b00; applyStimulus(32'hFFFF_FFFC); step();
    check("pc_wrap_plus4", pc_plus4_d, 32'h0);
    checkOutput("pc_wrap", 32'd0, 1'b1, 1'b0);

    stall = 1'b1; step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instr_d, 32'h13);
    check("mid_rst_pc_d", pc_d, 32'h0);
    check("mid_rst_pc_plus4", pc_plus4_d, 32'h4);
    checkOutput("mid_rst", 32'h0, 1'b0, 1'b0);
    stall = 1'b0;

    check("w_rst_A", {24'h0, A_w}, 32'd255);
    check("w_rst_pc_d", pc_d_w, 32'h3FC);
    check("w_rst_pc_plus4", pc_plus4_d_w, 32'h400);
    rst_w_n = 1'b1;
    step();
    check("w_boot_A", {24'h0, A_w}, 32'd255);
    check("w_boot_valid", {31'h0, valid_d_w}, 32'h0);
    step();
    check("w_fetch_A", {24'h0, A_w}, 32'd0);
    check("w_fetch_instr", instr_d_w, rom[255]);
    check("w_fetch_pc_d", pc_d_w, 32'h3FC);
    check("w_fetch_valid", {31'h0, valid_d_w}, 32'h1);
    step();
    check("w_wrap_instr", instr_d_w, rom[0]);
    check("w_wrap_pc_d", pc_d_w, 32'h400);
    check("w_halted", {31'h0, halted_w}, 32'h0);

    step();
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
